// File: rtl/led_ctrl.sv
// Multi-channel LED controller: DIRECT/BLINK/PWM/OFF modes, memory-mapped channel registers.
// Optional duty fading is enabled with `define LED_FADE_EN.
module led_ctrl #(
    parameter int          NUM_CH    = 8,
    parameter int          CNT_W     = 25,
    parameter int          PWM_W     = 8,
    parameter logic [15:0] BASE_ADDR = 16'hC010
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wen,
    input  logic [15:0]       waddr,
    input  logic [15:0]       wdata,
    input  logic [15:0]       raddr,
    output logic [15:0]       rdata,
    input  logic [NUM_CH-1:0] direct_in,
    output logic [NUM_CH-1:0] leds,
    output logic              status_led
);

    localparam logic [1:0] M_DIRECT = 2'd0;
    localparam logic [1:0] M_BLINK  = 2'd1;
    localparam logic [1:0] M_PWM    = 2'd2;

    logic [CNT_W-1:0]  cnt;
    logic [PWM_W-1:0]  pwm_cnt;
    logic [1:0]        mode_q [NUM_CH];
    logic [1:0]        rate_q [NUM_CH];
    logic [PWM_W-1:0]  duty_q [NUM_CH];
    logic [PWM_W-1:0]  duty_eff [NUM_CH];

    logic [15:0]       woff;
    logic [15:0]       roff;
    logic              win;
    logic              rin;
    logic [NUM_CH-1:0] wsel;
    logic [NUM_CH-1:0] rsel;
    logic [NUM_CH-1:0] led_nxt;
    logic [15:0]       rd_nxt;
    logic [3:0]        blk;
    logic              wdata_unused;

    assign wdata_unused = ^wdata;
    assign status_led   = cnt[CNT_W-1];
    assign blk          = cnt[CNT_W-1 -: 4];

    // Offsets only count when the address is at or above the base, so no wrap.
    assign woff = waddr - BASE_ADDR;
    assign roff = raddr - BASE_ADDR;
    assign win  = (waddr >= BASE_ADDR) && (woff < 16'(NUM_CH));
    assign rin  = (raddr >= BASE_ADDR) && (roff < 16'(NUM_CH));

    always_comb begin
        wsel    = '0;
        rsel    = '0;
        led_nxt = '0;
        rd_nxt  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wsel[i] = wen && win && (woff == 16'(i));
            rsel[i] = rin && (roff == 16'(i));
            unique case (mode_q[i])
                M_DIRECT: led_nxt[i] = direct_in[i];
                M_BLINK:  led_nxt[i] = blk[~rate_q[i]];
                M_PWM:    led_nxt[i] = pwm_cnt < duty_eff[i];
                default:  led_nxt[i] = 1'b0;
            endcase
            if (rsel[i]) begin
                rd_nxt[1:0]        = mode_q[i];
                rd_nxt[3:2]        = rate_q[i];
                rd_nxt[8 +: PWM_W] = duty_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt     <= '0;
            pwm_cnt <= '0;
            leds    <= '0;
            rdata   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i] <= '0;
                rate_q[i] <= '0;
                duty_q[i] <= '0;
            end
        end else begin
            cnt     <= cnt + 1'b1;
            pwm_cnt <= pwm_cnt + 1'b1;
            leds    <= led_nxt;
            rdata   <= rd_nxt;
            for (int i = 0; i < NUM_CH; i++) begin
                if (wsel[i]) begin
                    mode_q[i] <= wdata[1:0];
                    rate_q[i] <= wdata[3:2];
                    duty_q[i] <= wdata[8 +: PWM_W];
                end
            end
        end
    end

`ifdef LED_FADE_EN
    localparam int FADE_W = (CNT_W > 8) ? CNT_W - 8 : 1;

    logic fade_tick;

    assign fade_tick = &cnt[FADE_W-1:0];

    // Effective duty sits at 0 outside PWM and walks one step per tick inside it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) duty_eff[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (mode_q[i] != M_PWM) begin
                    duty_eff[i] <= '0;
                end else if (fade_tick) begin
                    if (duty_eff[i] < duty_q[i])
                        duty_eff[i] <= duty_eff[i] + 1'b1;
                    else if (duty_eff[i] > duty_q[i])
                        duty_eff[i] <= duty_eff[i] - 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) duty_eff[i] = duty_q[i];
    end
`endif

endmodule
